// File: rtl/divider_booths_inverse.sv
// divider_booths_inverse: sequential restoring divider, inverse companion of the
// Booth multiplier. Divides a 2N-bit dividend by an N-bit divisor, producing one
// quotient magnitude bit per clock, then applies the sign correction in a final
// FIX cycle. Shares the multiplier's load/done handshake.
//
// Ports:
//   clock      rising-edge system clock
//   clear      asynchronous active-high reset (priority over load)
//   load       start a division (accepted in IDLE or DONE)
//   dividend   2N-bit dividend
//   divisor    N-bit divisor
//   quotient   registered N-bit quotient (low N bits of the full result)
//   remainder  registered N-bit remainder
//   done       result valid, held until the next accepted load
//   overflow   quotient does not fit in N bits (valid with done)
//   div_zero   divisor was zero (valid with done)
//
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands;
// otherwise operands are unsigned and FIX is a pass-through.
//
// Timing: accept edge 0 -> ACCEPT; edge 1 -> BUSY (or DONE on divide by zero);
// edges 2..2N+1 iterate; edge 2N+2 leaves FIX with done=1.

module divider_booths_inverse #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           load,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           done,
  output logic           overflow,
  output logic           div_zero
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = (W2 > 1) ? $clog2(W2) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W2-1:0] dmag;   // dividend magnitude, shifted out MSB first
  logic [N-1:0]  vmag;   // divisor magnitude
  logic [N-1:0]  pr;     // partial remainder (always < vmag)
  logic [W2-1:0] qmag;   // quotient magnitude
  logic [CW-1:0] cnt;    // iteration counter 0..2N-1
  logic [N-1:0]  dlow;   // dividend low bits, reported as remainder on divide by zero

`ifdef DIVIDER_SIGNED_EN
  logic qneg;            // quotient must be negated in FIX
  logic rneg;            // remainder must be negated in FIX
  logic [W2-1:0] q_signed;
`endif

  logic [N:0]    shifted;
  logic          ge;
  logic [N-1:0]  diff;
  logic [N-1:0]  q_out;
  logic [N-1:0]  r_out;
  logic          ovf;

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (load) state_nxt = S_ACCEPT;
      S_ACCEPT:       state_nxt = (vmag == '0) ? S_DONE : S_BUSY;
      S_BUSY:         if (cnt == CW'(W2 - 1)) state_nxt = S_FIX;
      S_FIX:          state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor
  always_comb begin
    shifted = {pr, dmag[W2-1]};
    ge      = (shifted >= {1'b0, vmag});
    diff    = N'(shifted - {1'b0, vmag});
  end

  // Final result formatting and overflow detection
`ifdef DIVIDER_SIGNED_EN
  always_comb begin
    q_signed = qneg ? (W2'(0) - qmag) : qmag;
    q_out    = q_signed[N-1:0];
    r_out    = rneg ? (N'(0) - pr) : pr;
    // in range iff bits [2N-1:N-1] are all equal (sign extension of N-bit value)
    ovf      = !((&q_signed[W2-1:N-1]) || !(|q_signed[W2-1:N-1]));
  end
`else
  always_comb begin
    q_out = qmag[N-1:0];
    r_out = pr;
    ovf   = |qmag[W2-1:N];
  end
`endif

  // Datapath and output registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      dmag      <= '0;
      vmag      <= '0;
      pr        <= '0;
      qmag      <= '0;
      cnt       <= '0;
      dlow      <= '0;
`ifdef DIVIDER_SIGNED_EN
      qneg      <= 1'b0;
      rneg      <= 1'b0;
`endif
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load) begin
`ifdef DIVIDER_SIGNED_EN
            dmag <= dividend[W2-1] ? (W2'(0) - dividend) : dividend;
            vmag <= divisor[N-1]   ? (N'(0) - divisor)   : divisor;
            qneg <= dividend[W2-1] ^ divisor[N-1];
            rneg <= dividend[W2-1];
`else
            dmag <= dividend;
            vmag <= divisor;
`endif
            dlow     <= dividend[N-1:0];
            pr       <= '0;
            qmag     <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (vmag == '0) begin
            quotient  <= '1;
            remainder <= dlow;
            overflow  <= 1'b0;
            div_zero  <= 1'b1;
            done      <= 1'b1;
          end
        end
        S_BUSY: begin
          pr   <= ge ? diff : shifted[N-1:0];
          qmag <= {qmag[W2-2:0], ge};
          dmag <= {dmag[W2-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
        end
        S_FIX: begin
          quotient  <= q_out;
          remainder <= r_out;
          overflow  <= ovf;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_booths_inverse.sv
// Directed testbench for divider_booths_inverse (N=4). Expected values are
// hand-computed for both the signed and unsigned builds.

module tb_divider_booths_inverse;

  logic       clock;
  logic       clear;
  logic       load;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       done;
  logic       overflow;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

  divider_booths_inverse #(.N(4)) dut (
    .clock     (clock),
    .clear     (clear),
    .load      (load),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one division; lat is the edge (after the accepting edge 0) where done rises.
  // poke pulses load with a zero divisor while BUSY; it must be ignored.
  task automatic run_div(input string name, input logic [7:0] dvd, input logic [3:0] dsr,
                         input int lat, input logic [3:0] eq, input logic [3:0] er,
                         input logic eo, input logic ez, input bit poke);
    int edges;
    @(negedge clock);
    dividend = dvd;
    divisor  = dsr;
    load     = 1'b1;
    @(posedge clock);
    #1;
    load     = 1'b0;
    dividend = ~dvd;
    divisor  = dsr + 4'd1;
    check({name, ".done_drop"}, done, 0);
    check({name, ".ovf_clr"}, overflow, 0);
    check({name, ".dz_clr"}, div_zero, 0);
    edges = 0;
    while (!done && edges < 20) begin
      if (poke && edges == 2) begin
        load    = 1'b1;
        divisor = 4'd0;
      end
      @(posedge clock);
      #1;
      load = 1'b0;
      edges++;
    end
    check({name, ".latency"}, edges, lat);
    check({name, ".quotient"}, quotient, eq);
    check({name, ".remainder"}, remainder, er);
    check({name, ".overflow"}, overflow, eo);
    check({name, ".div_zero"}, div_zero, ez);
    repeat (2) @(posedge clock);
    #1;
    check({name, ".hold_done"}, done, 1);
    check({name, ".hold_q"}, quotient, eq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    clear    = 1'b1;
    load     = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    #12;
    check("rst.quotient", quotient, 0);
    check("rst.remainder", remainder, 0);
    check("rst.done", done, 0);
    check("rst.overflow", overflow, 0);
    check("rst.div_zero", div_zero, 0);
    @(negedge clock);
    clear = 1'b0;

    run_div("12div3",  8'd12, 4'd3, 10, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1);
`ifdef DIVIDER_SIGNED_EN
    run_div("m12div3", 8'hF4, 4'd3, 10, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0);
    run_div("m7div2",  8'hF9, 4'd2, 10, 4'hD, 4'hF, 1'b0, 1'b0, 1'b0);
`else
    run_div("244div3", 8'hF4, 4'd3, 10, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0);
    run_div("249div2", 8'hF9, 4'd2, 10, 4'hC, 4'h1, 1'b1, 1'b0, 1'b0);
`endif
    run_div("100div3", 8'd100, 4'd3, 10, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0);
    run_div("13div5",  8'h0D, 4'h5, 10, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    run_div("7div8",   8'h07, 4'h8, 10, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0);
    run_div("0div5",   8'h00, 4'h5, 10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    run_div("80div8",  8'h80, 4'h8, 10, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_div("F0divF",  8'hF0, 4'hF, 10, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_div("5Adiv0",  8'h5A, 4'h0, 1,  4'hF, 4'hA, 1'b0, 1'b1, 1'b0);

    // Clear mid-division: outputs still hold the previous result until clear
    @(negedge clock);
    dividend = 8'd12;
    divisor  = 4'd3;
    load     = 1'b1;
    @(posedge clock);
    #1;
    load = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    check("clr.quotient", quotient, 0);
    check("clr.remainder", remainder, 0);
    check("clr.done", done, 0);
    check("clr.overflow", overflow, 0);
    check("clr.div_zero", div_zero, 0);
    @(negedge clock);
    clear = 1'b0;

    run_div("after_clr", 8'd12, 4'd3, 10, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
